// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: synchronises raw lines, latches rising
// edges as pending, and holds one registered request until the core returns.
module irq_arbiter #(
  parameter int IRQ_NUM     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_lines_i,
  input  logic [IRQ_NUM-1:0] irq_mask_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [4:0]         irq_id_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic [IRQ_NUM-1:0] pending_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NUM-1:0] prev_q;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] pending_q, pending_d;
  logic [IRQ_NUM-1:0] cand;
  logic [IRQ_NUM-1:0] id_onehot;
  logic [IRQ_NUM-1:0] clr;
  logic [IRQ_NUM-1:0] ack_q, ack_d;
  logic [4:0]         winner;
  logic [4:0]         id_q, id_d;
  state_e             state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and the synchroniser chain shifts by exactly one stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_lines_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign cand = pending_q & irq_mask_i;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    winner = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (cand[i]) winner = 5'(i);
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      id_onehot[i] = (id_q == 5'(i));
    end
  end

  // A fresh edge in the clearing cycle re-sets the bit, so no event is lost.
  assign clr       = (state_q == BUSY && irq_ret_i) ? id_onehot : '0;
  assign pending_d = rise | (pending_q & ~clr);

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = BUSY;
          id_d    = winner;
        end
      end
      BUSY: begin
        if (irq_ret_i) begin
          state_d = IDLE;
          ack_d   = id_onehot;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      ack_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
    end
  end

  assign irq_req_o = (state_q == BUSY);
  assign irq_id_o  = id_q;
  assign irq_ack_o = ack_q;
  assign pending_o = pending_q;

endmodule
